// File: rtl/switch_input_port_pkg.sv
// Shared definitions for the switch input peripheral: bus width and register offsets.
package switch_input_port_pkg;

  localparam int BUS_W = 32;

  // Register select is addr[3:2]; the byte offset bits addr[1:0] are ignored.
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_CHANGED = 2'd1,
    REG_MASK    = 2'd2,
    REG_RSVD    = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, saturating debounce counter and the accepted level.
module switch_debounce_bit #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  // Events are combinational so the flag register sets on the same edge the level is accepted.
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);
  assign rise   = accept & sync2;
  assign fall   = accept & ~sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_input_port.sv
// CPU-readable switch port: debounced levels, sticky W1C change flags, interrupt mask and level irq.
module switch_input_port
  import switch_input_port_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch,
  input  logic             sel,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [3:0]       addr,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] rdata,
  output logic             rd_valid,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clr;
  logic [BUS_W-1:0] rd_mux;
  reg_sel_e         reg_sel;
  logic             rd_req;
  logic             wr_req;
  logic             unused_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (switch[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign reg_sel     = reg_sel_e'(addr[3:2]);
  assign rd_req      = sel & rd_en;
  assign wr_req      = sel & wr_en;
  assign clr         = (wr_req && reg_sel == REG_CHANGED) ? wdata[WIDTH-1:0] : '0;
  assign unused_bits = ^{addr[1:0], wdata};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA:    rd_mux[WIDTH-1:0] = stable;
      REG_CHANGED: rd_mux[WIDTH-1:0] = changed;
      REG_MASK:    rd_mux[WIDTH-1:0] = mask;
      default:     rd_mux = '0;
    endcase
  end

  // A new debounce event overrides a same-cycle W1C so no change is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed  <= '0;
      mask     <= '0;
      rdata    <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      changed  <= (changed & ~clr) | rise | fall;
      if (wr_req && reg_sel == REG_MASK) mask <= wdata[WIDTH-1:0];
      irq      <= |(changed & mask);
      rd_valid <= rd_req;
      if (rd_req) rdata <= rd_mux;
    end
  end

endmodule
